fiat_25519_carry_reduce: RTL

- Sequential downstream stage of the 32x32->64 unsigned limb multiplier in the fiat_25519_carry_square datapath.
- Accepts the 10 accumulated 64-bit column sums of the square, one column per beat.
- Runs the radix-2^25.5 carry chain, including the x19 wrap fold from limb 9 into limb 0.
- Streams out 10 reduced limbs on a valid/ready interface.

---
 rtl/fiat_25519_carry_reduce.sv | 104 ++++++++++
 1 files changed

// File: rtl/fiat_25519_carry_reduce.sv
// Carry-reduce stage for the fiat_25519 square datapath: loads 10 column sums,
// runs the radix-2^25.5 carry chain with the x19 wrap fold, and streams out 10 limbs.
module fiat_25519_carry_reduce #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 32,
    parameter int NUM_LIMBS  = 10,
    parameter int FOLD_CONST = 19
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);
    // Carry out of a 65-bit sum shifted by 25 needs IN_WIDTH-24 bits.
    localparam int CW = IN_WIDTH - 24;
    localparam logic [3:0] LAST = 4'(NUM_LIMBS - 1);

    typedef enum logic [2:0] {LOAD, CARRY, FOLD, FIX, OUT} state_t;

    state_t state, state_nxt;
    logic [3:0] idx;
    logic [NUM_LIMBS-1:0][IN_WIDTH-1:0] col;
    logic [CW-1:0] carry;
    logic [IN_WIDTH:0] t;
    logic in_fire, out_fire, at_last;

    assign at_last   = (idx == LAST);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? col[idx][OUT_WIDTH-1:0] : '0;
    assign busy      = !((state == LOAD) && (idx == 4'd0));

    always_comb begin
        t = {1'b0, col[idx]} + {{(IN_WIDTH + 1 - CW){1'b0}}, carry};
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && at_last) state_nxt = CARRY;
            CARRY:   if (at_last) state_nxt = FOLD;
            FOLD:    state_nxt = FIX;
            FIX:     state_nxt = OUT;
            OUT:     if (out_fire && at_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            idx   <= 4'd0;
            carry <= '0;
            col   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        col[idx] <= in_data;
                        idx      <= at_last ? 4'd0 : idx + 4'd1;
                        if (at_last) carry <= '0;
                    end
                end
                CARRY: begin
                    // Odd limbs are 25 bits wide, even limbs 26.
                    if (idx[0]) begin
                        col[idx] <= {{(IN_WIDTH - 25){1'b0}}, t[24:0]};
                        carry    <= t[IN_WIDTH:25];
                    end else begin
                        col[idx] <= {{(IN_WIDTH - 26){1'b0}}, t[25:0]};
                        carry    <= {1'b0, t[IN_WIDTH:26]};
                    end
                    idx <= at_last ? 4'd0 : idx + 4'd1;
                end
                FOLD: begin
                    col[0] <= col[0] + IN_WIDTH'(carry) * IN_WIDTH'(FOLD_CONST);
                end
                FIX: begin
                    col[0] <= {{(IN_WIDTH - 26){1'b0}}, col[0][25:0]};
                    col[1] <= col[1] + (col[0] >> 26);
                    carry  <= '0;
                    idx    <= 4'd0;
                end
                OUT: begin
                    if (out_fire) idx <= at_last ? 4'd0 : idx + 4'd1;
                end
                default: idx <= 4'd0;
            endcase
        end
    end
endmodule
